intbus_interf: RTL and testbench
================================

INTBUS_INTERF -- requirements
Module: intbus_interf

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the width of the bus word address.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the width of the bus data.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, meaning the number of cycles to wait for read data before aborting (minimum 1).
REQ-004 The block SHALL have the port clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-005 The block SHALL have the port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have the port cmd_valid, input, 1 bit: a host command is present.
REQ-007 The block SHALL have the port cmd_ready, output, 1 bit: the block accepts a command this cycle.
REQ-008 The block SHALL have the port cmd_write, input, 1 bit: 1 selects write, 0 selects read.
REQ-009 The block SHALL have the port cmd_base, input, ADDR_W bits: the slave base word address (byte address / 4).
REQ-010 The block SHALL have the port cmd_offs, input, ADDR_W bits: the register word offset within the slave.
REQ-011 The block SHALL have the port cmd_wdata, input, DATA_W bits: the write data.
REQ-012 The block SHALL have the port rsp_valid, output, 1 bit: a one-cycle completion pulse for each command.
REQ-013 The block SHALL have the port rsp_rdata, output, DATA_W bits: read data, valid while rsp_valid is 1.
REQ-014 The block SHALL have the port rsp_err, output, 1 bit: a read timed out; qualified by rsp_valid.
REQ-015 The block SHALL have the port bus_addr, output, ADDR_W bits: the word address driven to slaves.
REQ-016 The block SHALL have the port bus_wdata, output, DATA_W bits: the write data driven to slaves.
REQ-017 The block SHALL have the port bus_wr, output, 1 bit: a one-cycle write strobe.
REQ-018 The block SHALL have the port bus_rd, output, 1 bit: a one-cycle read strobe.
REQ-019 The block SHALL have the port bus_rdata, input, DATA_W bits: the OR of the slave read data.
REQ-020 The block SHALL have the port bus_rvalid, input, 1 bit: a slave returns read data this cycle.

Function
REQ-021 The block SHALL implement an FSM with the states IDLE, WR, RD, WAIT, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-022 On cmd_valid && cmd_ready, the block SHALL register bus_addr = cmd_base + cmd_offs (modulo 2^ADDR_W, wrap silently) and bus_wdata = cmd_wdata, then go to WR if cmd_write is 1, else to RD.
REQ-023 In WR, bus_wr SHALL be 1 for exactly one cycle and the FSM SHALL go to RESP; the write completes with no slave acknowledge.
REQ-024 In RD, bus_rd SHALL be 1 for exactly one cycle and the FSM SHALL go to WAIT with the timeout counter cleared.
REQ-025 In WAIT, on bus_rvalid the block SHALL capture rsp_rdata = bus_rdata, set rsp_err = 0, and go to RESP.
REQ-026 In WAIT, if TIMEOUT cycles elapse without bus_rvalid, the block SHALL set rsp_rdata = 0xDEADBEEF, set rsp_err = 1, and go to RESP.
REQ-027 If bus_rvalid arrives in the same cycle the counter expires, the block SHALL take the data path with rsp_err = 0.
REQ-028 In RESP, rsp_valid SHALL be 1 for one cycle and the FSM SHALL return to IDLE.
REQ-029 Write latency SHALL be: accept cycle, bus_wr on the following cycle, rsp_valid one cycle after bus_wr; a new command SHALL be acceptable the cycle after rsp_valid.
REQ-030 Read latency SHALL be: accept cycle, bus_rd on the following cycle, and rsp_valid one cycle after the bus_rvalid capture.
REQ-031 bus_rvalid outside WAIT SHALL be ignored.
REQ-032 bus_wr and bus_rd SHALL never both be 1 in the same cycle.
REQ-033 On a write, rsp_rdata SHALL be 0 and rsp_err SHALL be 0.
REQ-034 bus_addr and bus_wdata SHALL hold their values until the next accepted command.

Reset
REQ-035 While resetn = 0, the FSM SHALL be in IDLE.
REQ-036 While resetn = 0, cmd_ready, rsp_valid, rsp_err, bus_wr and bus_rd SHALL be 0, and bus_addr, bus_wdata and rsp_rdata SHALL be 0.
REQ-037 A reset asserted mid-transaction SHALL abort that transaction without issuing rsp_valid.
REQ-038 cmd_ready SHALL rise in the first clock cycle after resetn deasserts.

Verification
REQ-039 Read with cmd_base = 0x10000000, cmd_offs = 0, and slave bus_rvalid two cycles after bus_rd with bus_rdata = 0x0000ABCD -> bus_addr = 0x10000000, one bus_rd pulse, rsp_valid with rsp_rdata = 0x0000ABCD and rsp_err = 0.
REQ-040 Write with cmd_base = 0x10000000, cmd_offs = 3, cmd_wdata = 50 -> bus_addr = 0x10000003, bus_wdata = 0x32, one bus_wr pulse, rsp_valid the next cycle.
REQ-041 Read with no slave response -> rsp_valid exactly TIMEOUT+1 cycles after bus_rd (16 waiting cycles plus the transition), rsp_rdata = 0xDEADBEEF, rsp_err = 1.
REQ-042 Back-to-back writes to offsets 3, 4, 2 with data 50, 5, 0x1 -> three bus_wr pulses in order, each with its correct address and data, and cmd_ready low between them.
REQ-043 resetn asserted while in WAIT -> all outputs reach 0 immediately, no rsp_valid, and the next read completes normally.
REQ-044 cmd_base = 0xFFFFFFFF, cmd_offs = 2 -> bus_addr = 0x00000001.

Source files
------------

// File: rtl/intbus_if.sv
// Host command / response channel and slave bus of the internal register bus bridge.
// The bridge uses the slave view; the host and the bus slaves together use the master view.
interface intbus_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W-1:0] cmd_offs;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_wr;
    logic              bus_rd;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_rvalid;

    modport slave (
        input  cmd_valid, cmd_write, cmd_base, cmd_offs, cmd_wdata, bus_rdata, bus_rvalid,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, bus_addr, bus_wdata, bus_wr, bus_rd
    );

    modport master (
        output cmd_valid, cmd_write, cmd_base, cmd_offs, cmd_wdata, bus_rdata, bus_rvalid,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, bus_addr, bus_wdata, bus_wr, bus_rd
    );
endinterface

// File: rtl/intbus_interf.sv
// Bridge from single-outstanding host commands to strobed register-bus accesses,
// with a read timeout that returns 0xDEADBEEF and an error flag.
//
// state | meaning
// IDLE  | waiting for a host command (only state with cmd_ready)
// WR    | bus_wr strobe cycle
// RD    | bus_rd strobe cycle, timeout counter cleared
// WAIT  | waiting for bus_rvalid or timeout
// RESP  | rsp_valid pulse to the host
module intbus_interf #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic resetn,
    intbus_if.slave ifc
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WR, RD, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              accept;
    logic              expired;

    // Ready is gated by resetn so it stays low throughout reset.
    assign ifc.cmd_ready = (state == IDLE) && resetn;
    assign accept        = ifc.cmd_valid && ifc.cmd_ready;
    assign expired       = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = ifc.cmd_write ? WR : RD;
            WR:   state_nxt = RESP;
            RD:   state_nxt = WAIT;
            WAIT: if (ifc.bus_rvalid || expired) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= ifc.cmd_base + ifc.cmd_offs;
                wdata_q <= ifc.cmd_wdata;
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
            if (state == RD) begin
                cnt <= '0;
            end
            // Data wins over a timeout that expires in the same cycle.
            if (state == WAIT) begin
                if (ifc.bus_rvalid) begin
                    rdata_q <= ifc.bus_rdata;
                    err_q   <= 1'b0;
                end else if (expired) begin
                    rdata_q <= DATA_W'(32'hDEADBEEF);
                    err_q   <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign ifc.bus_wr    = (state == WR);
    assign ifc.bus_rd    = (state == RD);
    assign ifc.rsp_valid = (state == RESP);
    assign ifc.bus_addr  = addr_q;
    assign ifc.bus_wdata = wdata_q;
    assign ifc.rsp_rdata = rdata_q;
    assign ifc.rsp_err   = err_q;
endmodule

// File: tb/tb_intbus_interf.sv
// Table-driven bench for intbus_interf with bus-side and response-side scoreboards.
module tb_intbus_interf;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    intbus_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

    intbus_interf #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .ifc    (ifc)
    );

    // d = cycle (relative to the strobe cycle) in which bus_rvalid is driven; -1 = never
    typedef struct {
        bit          wr;
        logic [31:0] base;
        logic [31:0] offs;
        logic [31:0] wdata;
        int          d;
        logic [31:0] sdata;
        logic [31:0] exp_addr;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          wr;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        int          lat;
    } rsp_exp_t;

    bus_exp_t bus_q[$];
    rsp_exp_t rsp_q[$];
    vec_t     vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic fail(input string name);
        n_total++;
        $display("FAIL %s: event missing at %0t", name, $time);
    endtask

    function automatic int exp_lat(input vec_t v);
        if (v.wr) return 1;
        if (v.d >= 1 && v.d <= TIMEOUT) return v.d + 1;
        return TIMEOUT + 1;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, 32'(ifc.cmd_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(ifc.rsp_valid), 0);
        chk({tag, "_rsp_err"},   32'(ifc.rsp_err),   0);
        chk({tag, "_bus_wr"},    32'(ifc.bus_wr),    0);
        chk({tag, "_bus_rd"},    32'(ifc.bus_rd),    0);
        chk({tag, "_bus_addr"},  ifc.bus_addr,       0);
        chk({tag, "_bus_wdata"}, ifc.bus_wdata,      0);
        chk({tag, "_rsp_rdata"}, ifc.rsp_rdata,      0);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the response.
    task automatic run_cmd(input vec_t v);
        bus_exp_t be;
        rsp_exp_t re;
        int       cyc;
        bit       done;
        chk("cmd_ready_idle", 32'(ifc.cmd_ready), 1);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_write = v.wr;
        ifc.cmd_base  = v.base;
        ifc.cmd_offs  = v.offs;
        ifc.cmd_wdata = v.wdata;
        bus_q.push_back('{addr: v.exp_addr, wdata: v.wdata, wr: v.wr});
        rsp_q.push_back('{rdata: v.exp_rdata, err: v.exp_err, lat: exp_lat(v)});
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
        be = bus_q.pop_front();
        chk("bus_wr_strobe", 32'(ifc.bus_wr), 32'(be.wr));
        chk("bus_rd_strobe", 32'(ifc.bus_rd), 32'(!be.wr));
        chk("bus_addr", ifc.bus_addr, be.addr);
        chk("bus_wdata", ifc.bus_wdata, be.wdata);
        chk("cmd_ready_busy", 32'(ifc.cmd_ready), 0);
        ifc.bus_rdata  = v.sdata;
        ifc.bus_rvalid = (v.d == 0);
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < TIMEOUT + 8) begin
            @(negedge clk);
            cyc++;
            if (ifc.rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    fail("rsp_unexpected");
                end else begin
                    re = rsp_q.pop_front();
                    chk("rsp_latency", 32'(cyc), 32'(re.lat));
                    chk("rsp_rdata", ifc.rsp_rdata, re.rdata);
                    chk("rsp_err", 32'(ifc.rsp_err), 32'(re.err));
                    chk("bus_quiet_resp", {30'd0, ifc.bus_wr, ifc.bus_rd}, 0);
                end
                done = 1'b1;
            end else begin
                chk("busy_quiet", {29'd0, ifc.bus_wr, ifc.bus_rd, ifc.cmd_ready}, 0);
                chk("hold_addr", ifc.bus_addr, be.addr);
            end
            ifc.bus_rvalid = (cyc == v.d);
        end
        if (!done) fail("rsp_timeout");
        @(negedge clk);
        ifc.bus_rvalid = 1'b0;
        chk("rsp_single_pulse", 32'(ifc.rsp_valid), 0);
        chk("hold_wdata", ifc.bus_wdata, be.wdata);
    endtask

    initial begin
        ifc.cmd_valid  = 1'b0;
        ifc.cmd_write  = 1'b0;
        ifc.cmd_base   = '0;
        ifc.cmd_offs   = '0;
        ifc.cmd_wdata  = '0;
        ifc.bus_rdata  = '0;
        ifc.bus_rvalid = 1'b0;

        //          wr  base          offs          wdata         d            sdata         exp_addr      exp_rdata     err
        vecs.push_back('{1'b0, 32'h1000_0000, 32'h0,        32'h0,        2,           32'h0000_ABCD, 32'h1000_0000, 32'h0000_ABCD, 1'b0});
        vecs.push_back('{1'b1, 32'h1000_0000, 32'h3,        32'd50,       -1,          32'h0,        32'h1000_0003, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h1000_0000, 32'h4,        32'd5,        -1,          32'h0,        32'h1000_0004, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h1000_0000, 32'h2,        32'h1,        -1,          32'h0,        32'h1000_0002, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h1000_0000, 32'h5,        32'h0,        -1,          32'h0,        32'h1000_0005, 32'hDEAD_BEEF, 1'b1});
        vecs.push_back('{1'b1, 32'hFFFF_FFFF, 32'h2,        32'hA5A5,     -1,          32'h0,        32'h0000_0001, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0000_0040, 32'h1,        32'h0,        TIMEOUT,     32'h1234_5678, 32'h0000_0041, 32'h1234_5678, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0040, 32'h2,        32'h0,        TIMEOUT + 1, 32'h0000_0055, 32'h0000_0042, 32'hDEAD_BEEF, 1'b1});
        vecs.push_back('{1'b0, 32'h0000_0100, 32'h0,        32'h0,        1,           32'hFFFF_FFFF, 32'h0000_0100, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0200, 32'h7,        32'h0,        0,           32'h0000_0077, 32'h0000_0207, 32'hDEAD_BEEF, 1'b1});
        vecs.push_back('{1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 32'hCAFE_F00D, 0,          32'h0000_0099, 32'hFFFF_FFFF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0000_0020, 32'h10,       32'h0,        3,           32'h0BAD_CAFE, 32'h0000_0030, 32'h0BAD_CAFE, 1'b0});

        #3;
        chk_all_zero("reset");
        @(posedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(ifc.cmd_ready), 1);

        foreach (vecs[i]) run_cmd(vecs[i]);

        // Reset while waiting for read data: abort without a response.
        ifc.cmd_valid = 1'b1;
        ifc.cmd_write = 1'b0;
        ifc.cmd_base  = 32'h0000_0300;
        ifc.cmd_offs  = 32'h4;
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
        chk("abort_rd_strobe", 32'(ifc.bus_rd), 1);
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk_all_zero("abort");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_no_rsp", {30'd0, ifc.rsp_valid, ifc.cmd_ready}, 0);
        end
        @(posedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        chk("ready_after_abort", 32'(ifc.cmd_ready), 1);
        run_cmd(vecs[0]);
        run_cmd(vecs[1]);

        chk("scoreboard_empty", 32'(bus_q.size() + rsp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // bus_wr and bus_rd must never overlap.
    always @(negedge clk) begin
        if (resetn && ifc.bus_wr && ifc.bus_rd) fail("strobe_overlap");
    end
endmodule
